// File: rtl/spi_reg_ctrl_pkg.sv
// rtl/spi_reg_ctrl_pkg.sv - register data type and SPI frame-controller types
package regPKG;
    localparam int REG_DATA_W = 16;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

package spiPKG;
    localparam int ADDR_W     = 7;
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_HI,
        WR_LO,
        RD_FETCH,
        RD_HI,
        RD_LO
    } ctrl_state_t;

    // Command byte layout: rw occupies bit CMD_RW_BIT, address below it
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
    } cmd_t;
endpackage

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI byte stream to register-file command controller
// Optional: SPI_REG_CTRL_AUTOINC_EN advances the address per register in bursts.
module spi_reg_ctrl #(
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 64,
    parameter int DATA_W   = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              cmd_err,
    output logic              busy
);
    import spiPKG::*;
    import regPKG::*;

    ctrl_state_t       state;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wr_hi_q;
    reg_data_t         rdata_q;
    logic [1:0]        fetch_cnt;
    cmd_t              cmd_in;
    logic              addr_ok;
    reg_data_t         fetch_data;
    logic [ADDR_W-1:0] addr_next;

    assign cmd_in     = cmd_t'(rx_byte);
    assign addr_ok    = int'(addr_q) < NUM_REGS;
    assign fetch_data = addr_ok ? reg_data_t'(reg_rdata) : '0;
    assign busy       = (state != IDLE);

`ifdef SPI_REG_CTRL_AUTOINC_EN
    assign addr_next = addr_q + ADDR_W'(1);
`else
    assign addr_next = addr_q;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wr_hi_q   <= '0;
            rdata_q   <= '0;
            fetch_cnt <= '0;
            tx_byte   <= '0;
            tx_load   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            reg_we  <= 1'b0;
            reg_re  <= 1'b0;
            cmd_err <= 1'b0;

            // Frame close beats any byte arriving on the same cycle
            if (state != IDLE && !cs_active) begin
                state     <= IDLE;
                fetch_cnt <= '0;
                cmd_err   <= (state == WR_LO);
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_active) state <= CMD;
                    end
                    CMD: begin
                        if (rx_valid) begin
                            addr_q    <= ADDR_W'(cmd_in.addr);
                            fetch_cnt <= '0;
                            state     <= cmd_in.rw ? RD_FETCH : WR_HI;
                        end
                    end
                    WR_HI: begin
                        if (rx_valid) begin
                            wr_hi_q <= rx_byte;
                            state   <= WR_LO;
                        end
                    end
                    WR_LO: begin
                        if (rx_valid) begin
                            reg_addr  <= addr_q;
                            reg_wdata <= DATA_W'({wr_hi_q, rx_byte});
                            reg_we    <= addr_ok;
                            cmd_err   <= !addr_ok;
                            addr_q    <= addr_next;
                            state     <= WR_HI;
                        end
                    end
                    RD_FETCH: begin
                        // cnt 0: issue strobe, cnt 1: register file responds, cnt 2: capture
                        case (fetch_cnt)
                            2'd0: begin
                                reg_addr  <= addr_q;
                                reg_re    <= addr_ok;
                                fetch_cnt <= 2'd1;
                            end
                            2'd1: fetch_cnt <= 2'd2;
                            default: begin
                                rdata_q   <= fetch_data;
                                cmd_err   <= !addr_ok;
                                tx_byte   <= fetch_data[$bits(reg_data_t)-1 -: 8];
                                tx_load   <= 1'b1;
                                fetch_cnt <= '0;
                                state     <= RD_HI;
                            end
                        endcase
                    end
                    RD_HI: begin
                        if (rx_valid) begin
                            tx_byte <= rdata_q[7:0];
                            tx_load <= 1'b1;
                            state   <= RD_LO;
                        end
                    end
                    RD_LO: begin
                        if (rx_valid) begin
                            addr_q    <= addr_next;
                            fetch_cnt <= '0;
                            state     <= RD_FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - directed self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;
    logic        clk_in = 1'b0;
    logic        reset;
    logic        cs_active;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        tx_load;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata = '0;
    logic        cmd_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [0:63];
    logic [6:0]  we_addr_q [$];
    logic [15:0] we_data_q [$];
    logic [6:0]  re_addr_q [$];
    logic [7:0]  tx_q [$];
    int          err_cnt  = 0;
    int          both_cnt = 0;

    spi_reg_ctrl #(.ADDR_W(7), .NUM_REGS(64), .DATA_W(16)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cs_active (cs_active),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .tx_load   (tx_load),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .cmd_err   (cmd_err),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (reg_re) reg_rdata <= (reg_addr < 7'd64) ? model[reg_addr[5:0]] : 16'hDEAD;
    end

    always @(negedge clk_in) begin
        if (reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) re_addr_q.push_back(reg_addr);
        if (tx_load) tx_q.push_back(tx_byte);
        if (cmd_err) err_cnt <= err_cnt + 1;
        if (reg_we && reg_re) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
        tx_q.delete();
        err_cnt = 0;
    endtask

    task automatic open_frame();
        @(negedge clk_in);
        clear_mon();
        cs_active = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic close_frame();
        cs_active = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
        repeat (16) @(negedge clk_in);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = 16'(i * 3);
        model[3] = 16'hBEEF;
        model[4] = 16'h1357;
        reset = 1'b1; cs_active = 1'b0; rx_valid = 1'b0; rx_byte = '0;
        repeat (3) @(negedge clk_in);
        check("rst_tx_byte", 32'(tx_byte), 32'h0);
        check("rst_strobes", {28'h0, tx_load, reg_we, reg_re, cmd_err}, 32'h0);
        check("rst_addr_wdata", {9'h0, reg_addr, reg_wdata}, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        // single write
        open_frame();
        check("frame_busy", 32'(busy), 32'h1);
        send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
        close_frame();
        check("wr1_cnt", we_addr_q.size(), 1);
        check("wr1_addr", 32'(we_addr_q[0]), 32'h05);
        check("wr1_data", 32'(we_data_q[0]), 32'h1234);
        check("wr1_err", err_cnt, 0);
        check("wr1_busy_end", 32'(busy), 32'h0);

        // burst write
        open_frame();
        send_byte(8'h10); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        close_frame();
        check("burst_cnt", we_addr_q.size(), 2);
        check("burst_data0", 32'(we_data_q[0]), 32'hAABB);
        check("burst_addr0", 32'(we_addr_q[0]), 32'h10);
        check("burst_data1", 32'(we_data_q[1]), 32'hCCDD);
`ifdef SPI_REG_CTRL_AUTOINC_EN
        check("burst_addr1", 32'(we_addr_q[1]), 32'h11);
`else
        check("burst_addr1", 32'(we_addr_q[1]), 32'h10);
`endif

        // read of register 3, then the follow-on fetch
        open_frame();
        send_byte(8'h83);
        check("rd_re_cnt", re_addr_q.size(), 1);
        check("rd_re_addr", 32'(re_addr_q[0]), 32'h03);
        send_byte(8'h00); send_byte(8'h00);
        close_frame();
        check("rd_tx_cnt", tx_q.size(), 3);
        check("rd_tx_hi", 32'(tx_q[0]), 32'hBE);
        check("rd_tx_lo", 32'(tx_q[1]), 32'hEF);
`ifdef SPI_REG_CTRL_AUTOINC_EN
        check("rd_next_addr", 32'(re_addr_q[1]), 32'h04);
        check("rd_next_tx", 32'(tx_q[2]), 32'h13);
`else
        check("rd_next_addr", 32'(re_addr_q[1]), 32'h03);
        check("rd_next_tx", 32'(tx_q[2]), 32'hBE);
`endif
        check("rd_err", err_cnt, 0);
        check("no_we_re_overlap", both_cnt, 0);

        // out-of-range write and read
        open_frame();
        send_byte(8'h50); send_byte(8'h01); send_byte(8'h02);
        close_frame();
        check("oor_wr_we", we_addr_q.size(), 0);
        check("oor_wr_err", err_cnt, 1);
        open_frame();
        send_byte(8'hD0);
        check("oor_rd_re", re_addr_q.size(), 0);
        send_byte(8'h00);
        close_frame();
        check("oor_rd_err", err_cnt, 1);
        check("oor_rd_tx_cnt", tx_q.size(), 2);
        check("oor_rd_tx", {16'h0, tx_q[0], tx_q[1]}, 32'h0);

        // abort inside a write, then a normal frame
        open_frame();
        send_byte(8'h07); send_byte(8'h11);
        cs_active = 1'b0;
        @(negedge clk_in);
        check("abort_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk_in);
        check("abort_we", we_addr_q.size(), 0);
        check("abort_err", err_cnt, 1);
        open_frame();
        send_byte(8'h02); send_byte(8'h55); send_byte(8'h66);
        close_frame();
        check("post_abort_wr", {9'h0, we_addr_q[0], we_data_q[0]}, {9'h0, 7'h02, 16'h5566});
        check("post_abort_err", err_cnt, 0);

        // wrap at 0x7F
        open_frame();
        send_byte(8'h7F); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        close_frame();
`ifdef SPI_REG_CTRL_AUTOINC_EN
        check("wrap_err", err_cnt, 1);
        check("wrap_cnt", we_addr_q.size(), 1);
        check("wrap_wr", {9'h0, we_addr_q[0], we_data_q[0]}, {9'h0, 7'h00, 16'h0304});
`else
        check("wrap_err", err_cnt, 2);
        check("wrap_cnt", we_addr_q.size(), 0);
`endif

        // rx_valid outside a frame is ignored
        clear_mon();
        send_byte(8'h01);
        check("idle_rx_busy", 32'(busy), 32'h0);
        check("idle_rx_err", err_cnt, 0);

        // reset lands together with the low byte of a write
        open_frame();
        send_byte(8'h01); send_byte(8'hAA);
        rx_byte = 8'hBB; rx_valid = 1'b1; reset = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
        check("midrst_strobes", {28'h0, tx_load, reg_we, reg_re, cmd_err}, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_addr_wdata", {9'h0, reg_addr, reg_wdata}, 32'h0);
        cs_active = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        check("midrst_no_we", we_addr_q.size(), 0);
        check("midrst_no_err", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Frame-level controller between spi_slave_dataxceive and the synth register file. Parses received SPI bytes into register commands (single and burst read/write) and issues register-file strobes. Supplies the next outbound byte to the slave for read data. Runs entirely in the clk_in domain and consumes already-synchronised slave strobes.

Parameters:
ADDR_W, 7, register address width (command byte bits 6:0)
NUM_REGS, 64, implemented registers; addresses >= NUM_REGS are out of range
DATA_W, 16, register width, fixed at two bytes, MSB first

Ports:
clk_in  in  1  system clock
reset  in  1  synchronous, active-high reset
cs_active  in  1  synchronised inverse of spi_nCS; high while a frame is open
rx_valid  in  1  one-cycle pulse when the slave has a complete received byte
rx_byte  in  8  received byte, valid with rx_valid
tx_byte  out  8  next byte to shift out; drives the slave's spi_word_in
tx_load  out  1  one-cycle pulse when tx_byte is updated
reg_addr  out  ADDR_W  register address
reg_wdata  out  DATA_W  register write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  DATA_W  read data, valid exactly 1 cycle after reg_re
cmd_err  out  1  one-cycle pulse on an out-of-range access or an aborted frame
busy  out  1  high when the state is not IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address and data latches 0.
- Command byte: bit7 selects read (1) or write (0); bits 6:0 hold the start address.
- IDLE -> CMD when cs_active rises.
- CMD, on rx_valid:
  - Latch the address and direction.
  - Write direction -> WR_HI.
  - Read direction -> RD_FETCH.
- WR_HI, on rx_valid: latch the high byte -> WR_LO.
- WR_LO, on rx_valid:
  - Form reg_wdata as {high byte, rx_byte}.
  - Pulse reg_we on the same cycle if the address is in range; otherwise pulse cmd_err and suppress reg_we.
  - Advance the address -> WR_HI.
- RD_FETCH:
  - Pulse reg_re one cycle after entry.
  - The following cycle, capture reg_rdata (0x0000 if out of range, plus a cmd_err pulse).
  - Drive tx_byte with the high byte and pulse tx_load -> RD_HI.
- RD_HI, on rx_valid (dummy byte): tx_byte = low byte, tx_load pulse -> RD_LO.
- RD_LO, on rx_valid: advance the address -> RD_FETCH.
- Latency: rx_valid to reg_we is 1 cycle (registered). Read data is presented within 3 cycles of rx_valid. The slave's byte period is at least 16 clk_in cycles, so this meets its timing.
- Address advance: +1 modulo 2^ADDR_W, so 0x7F wraps to 0x00.
- cs_active falling in any state returns to IDLE the next cycle.
  - A partial write (WR_LO entered, low byte not received) is discarded and cmd_err pulses.
  - A clean end in WR_HI, RD_HI or RD_LO is not an error.
- rx_valid while in IDLE is ignored.
- rx_valid and cs_active falling on the same cycle: the abort wins and the byte is dropped.
- reset asserted mid-frame: state returns to IDLE and all strobes drop the same cycle.
- reg_we and reg_re are never high together. Each is at most one pulse per register.

Optional Feature:
SPI_REG_CTRL_AUTOINC_EN
- Defined: burst transfers advance the address after each register, as described above.
- Undefined: the address stays fixed for the whole frame, so repeated pairs rewrite or re-read the same register and no wrap occurs.

Decomposition:
- spiPKG holds:
  - ctrl_state_t enum (IDLE, CMD, WR_HI, WR_LO, RD_FETCH, RD_HI, RD_LO)
  - CMD_RW_BIT = 7
  - ADDR_W
  - the cmd_t packed struct {rw, addr}
- The register data type comes from regPKG::reg_data_t.
- No sub-module: a single FSM plus latches.

Test Plan:
- Write frame 0x05,0x12,0x34 -> one reg_we with reg_addr=0x05 and reg_wdata=0x1234; no cmd_err.
- Burst write 0x10,0xAA,0xBB,0xCC,0xDD -> writes 0xAABB@0x10 and 0xCCDD@0x11 (with AUTOINC_EN); without the macro, both writes go to 0x10.
- Read frame 0x83 with model reg[3]=0xBEEF and two dummy bytes -> tx_byte 0xBE then 0xEF, each with a tx_load pulse; one reg_re with reg_addr=0x03.
- Out-of-range write 0x50,0x01,0x02 (NUM_REGS=64) -> no reg_we, one cmd_err pulse; read 0xD0 returns 0x00,0x00 and one cmd_err pulse.
- Abort: 0x07,0x11 then cs_active falls -> no reg_we, one cmd_err pulse, busy=0 the next cycle; the next frame is parsed normally.
- Wrap: burst write at 0x7F covering two registers -> the second write lands at 0x00 (out-of-range rule applied to 0x7F); reset pulsed mid-frame -> all outputs 0 the next cycle.
